// File: rtl/camera_defs.sv
// camera_defs: frame geometry, RGB332 reference colours and capture FSM encoding
package camera_defs;

    localparam int SCREEN_WIDTH  = 176;
    localparam int SCREEN_HEIGHT = 144;

    localparam logic [7:0] RED  = 8'hE0;
    localparam logic [7:0] BLUE = 8'h03;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        WAIT_LINE,
        FIRST_BYTE,
        SECOND_BYTE
    } state_t;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: registered copy of a level plus rise/fall strobes against it
module sync_edge_detect (
    input  logic CLK,
    input  logic RESET,
    input  logic SIG,
    output logic RISE,
    output logic FALL
);

    logic sig_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) sig_d <= 1'b0;
        else       sig_d <= SIG;
    end

    assign RISE = SIG & ~sig_d;
    assign FALL = ~SIG & sig_d;

endmodule

// File: rtl/camera_downsampler.sv
// camera_downsampler: OV7670 RGB565 byte stream to RGB332 frame-buffer writes
module camera_downsampler #(
    parameter int SCREEN_WIDTH  = camera_defs::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = camera_defs::SCREEN_HEIGHT
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] CAM_DATA,
    input  logic       CAM_HREF,
    input  logic       CAM_VSYNC,
    output logic [7:0] PIXEL_OUT,
    output logic       W_EN,
    output logic [9:0] WRITE_X,
    output logic [9:0] WRITE_Y,
    output logic       FRAME_DONE
);

    import camera_defs::*;

    localparam logic [9:0] X_LIM = 10'(SCREEN_WIDTH);
    localparam logic [9:0] Y_LIM = 10'(SCREEN_HEIGHT);

    state_t     state, state_n;
    logic [5:0] b1;
    logic [9:0] x, y;
    logic       href_fall, href_rise_unused, vsync_rise, vsync_fall;
    logic       done_n, take_b1, build, clr_xy, line_end;

    sync_edge_detect u_href (
        .CLK   (CLK),
        .RESET (RESET),
        .SIG   (CAM_HREF),
        .RISE  (href_rise_unused),
        .FALL  (href_fall)
    );

    sync_edge_detect u_vsync (
        .CLK   (CLK),
        .RESET (RESET),
        .SIG   (CAM_VSYNC),
        .RISE  (vsync_rise),
        .FALL  (vsync_fall)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= WAIT_FRAME;
        else       state <= state_n;
    end

    // A VSYNC rise outranks everything, including a second byte in the same cycle
    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        take_b1 = 1'b0;
        build   = 1'b0;
        clr_xy  = 1'b0;
        if (state != WAIT_FRAME && vsync_rise) begin
            state_n = WAIT_FRAME;
            done_n  = 1'b1;
        end else begin
            case (state)
                WAIT_FRAME: begin
                    state_n = vsync_fall ? WAIT_LINE : WAIT_FRAME;
                    clr_xy  = vsync_fall;
                end
                WAIT_LINE: begin
                    take_b1 = CAM_HREF && !CAM_VSYNC;
                    state_n = take_b1 ? SECOND_BYTE : WAIT_LINE;
                end
                FIRST_BYTE: begin
                    take_b1 = CAM_HREF;
                    state_n = CAM_HREF ? SECOND_BYTE : WAIT_LINE;
                end
                SECOND_BYTE: begin
                    build   = CAM_HREF;
                    state_n = CAM_HREF ? FIRST_BYTE : WAIT_LINE;
                end
                default: state_n = WAIT_FRAME;
            endcase
        end
        line_end = state != WAIT_FRAME && !done_n && href_fall && x != 10'd0;
    end

    // Only the RGB332-relevant bits of the first byte are kept
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            b1         <= '0;
            x          <= '0;
            y          <= '0;
            PIXEL_OUT  <= '0;
            W_EN       <= 1'b0;
            WRITE_X    <= '0;
            WRITE_Y    <= '0;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= done_n;
            W_EN       <= build && x < X_LIM && y < Y_LIM;
            if (take_b1) b1 <= {CAM_DATA[7:5], CAM_DATA[2:0]};
            if (build) begin
                PIXEL_OUT <= {b1, CAM_DATA[4:3]};
                WRITE_X   <= x;
                WRITE_Y   <= y;
            end
            if (clr_xy) begin
                x <= '0;
                y <= '0;
            end else if (build) begin
                x <= sat_inc(x);
            end else if (line_end) begin
                x <= '0;
                y <= sat_inc(y);
            end
        end
    end

endmodule
